index_packer: RTL
=================

# index_packer

Write-side counterpart of the BRAM index unpacker. Accepts a stream of 16-bit column indices one per cycle and packs them four at a time into a 64-bit index word for the memory control unit. Lane order matches the unpacker's slice order, so a word written by this block and re-read by the unpacker returns the indices in arrival order. It sits between the sparse-format encoder, which produces the indices, and the memory control unit, which writes the index slots.

## Interface
Parameters:
- PAD, 16'hFFFF, fill value for unused lanes of a flushed partial word.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- idxValid  in  1  indexIn is valid this cycle.
- indexIn  in  16  index value.
- idxReady  out  1  packer can accept an index this cycle.
- flush  in  1  close the current partial word and emit it.
- indices  out  64  packed word; lane k = bits [16k+15:16k].
- wordCount  out  3  number of real indices in indices, 1..4.
- wordValid  out  1  indices and wordCount are valid.
- wordReady  in  1  memory control unit accepts the word this cycle.

## Operation
- Index accept: idxValid && idxReady at a rising edge.
- Word accept: wordValid && wordReady at a rising edge.
- Assembly register: 64-bit, plus a 2-bit fill pointer fillPtr (0..3). The accepted index is written to lane fillPtr, then fillPtr increments, wrapping 3→0.
- Output register: holds indices/wordCount/wordValid. It is loaded by either of two events:
  - Full event: the index is accepted with fillPtr==3. The loaded word is all four lanes, wordCount=4.
  - Flush event: flush=1 with at least one index held, counting an index accepted in the same cycle. Lanes fillPtr..3 (after that cycle's write) are filled with PAD, and wordCount = number of real lanes.
- When a word loads, the assembly lanes reset to PAD and fillPtr resets to 0.
- Flush with no held index and no index accepted that cycle has no effect. No empty word is ever emitted.
- Flush in the same cycle as an index that completes a word (fillPtr==3): a single normal full word, wordCount=4.
- flush is a single-cycle request. It is consumed on the cycle it is seen, whether or not idxValid is high.
- Output hold: indices and wordCount are stable while wordValid=1 && !wordReady. wordValid clears on a word accept unless a new word loads in that same cycle.
- Backpressure: idxReady = !(wordValid && !wordReady).
  - Index acceptance stops only while an undelivered word sits in the output register.
  - Rule applied uniformly, including when fillPtr<3. This keeps flush handling simple.
  - idxReady is combinational from wordValid and wordReady only, never from idxValid.
- Flush while idxReady=0: the held partial word stays in assembly and is not emitted. flush must be reasserted once idxReady=1; the upstream encoder holds it until then.
- idxValid while idxReady=0: the index is ignored; the upstream holds it.

## Timing
- Reset (rst_n=0, asynchronous): fillPtr=0, assembly lanes=PAD, indices=64'h0, wordCount=0, wordValid=0. idxReady therefore reads 1.
- Latency: the 4th index accepted at edge N gives wordValid=1 from edge N onward, i.e. visible in the cycle after N. Flush latency is the same: one edge.
- Throughput: one index per cycle sustained when wordReady is held high. wordValid then pulses every 4th cycle.
- Simultaneous word accept and new word load: the output register takes the new word and wordValid stays 1 with no bubble.
- Reset mid-word or with wordValid=1: all held and partial data is discarded and no word is emitted. After rst_n rises, packing restarts at lane 0.
- All outputs except idxReady are registered.

## Test plan
- Reset then indices 0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles, wordReady=1 → one cycle after the 4th: indices=64'h0004_0003_0002_0001, wordCount=4, wordValid=1 for exactly one cycle.
- Indices 0x00A0,0x00A1 then flush alone → indices=64'hFFFF_FFFF_00A1_00A0, wordCount=2. The next index 0x00B0 lands in lane 0.
- wordReady=0 with 8 indices offered continuously → first word held stable, idxReady drops to 0 after the 4th index, no index lost. Raise wordReady → both words delivered in order 1..4, 5..8.
- Flush with fillPtr=0 and idxValid=0 → no wordValid. Flush together with the 4th index 0x0D → one word, wordCount=4, no extra padded word.
- Continuous stream of 12 indices with wordReady=1 → three words back-to-back every 4th cycle, idxReady never drops.
- rst_n pulsed low after 3 indices with wordValid=1 → wordValid=0 and indices=0 immediately. Then 4 new indices → word contains only the new ones.

Source files
------------

// File: rtl/index_packer.sv
// ---------------------------------------------------------------------------
// index_packer
//
// Packs a stream of 16-bit column indices, one per cycle, into 64-bit index
// words for the memory control unit. Lane k holds the k-th index of a word
// (bits [16k+15:16k]), matching the slice order of the BRAM index unpacker.
// A flush closes a partial word early and pads its unused lanes with PAD.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   idxValid   in   1   indexIn valid this cycle
//   indexIn    in  16   index value
//   idxReady   out  1   an index can be accepted this cycle
//   flush      in   1   close and emit the current partial word
//   indices    out 64   packed word
//   wordCount  out  3   real indices in the word (1..4)
//   wordValid  out  1   indices/wordCount valid
//   wordReady  in   1   downstream takes the word this cycle
// ---------------------------------------------------------------------------
module index_packer #(
    parameter logic [15:0] PAD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idxValid,
    input  logic [15:0] indexIn,
    output logic        idxReady,
    input  logic        flush,
    output logic [63:0] indices,
    output logic [2:0]  wordCount,
    output logic        wordValid,
    input  logic        wordReady
);

    logic [63:0] asm_q, asm_d;
    logic [1:0]  fill_ptr_q, fill_ptr_d;
    logic [63:0] indices_q, indices_d;
    logic [2:0]  word_count_q, word_count_d;
    logic        word_valid_q, word_valid_d;

    logic        idx_acc;
    logic        full_ev;
    logic        flush_ev;
    logic [2:0]  held_cnt;
    logic [63:0] lanes_w;

    // Stall everything while an undelivered word occupies the output
    // register, even for partial words, so a flush never needs a second
    // output slot.
    assign idxReady = !(word_valid_q && !wordReady);

    always_comb begin
        asm_d        = asm_q;
        fill_ptr_d   = fill_ptr_q;
        indices_d    = indices_q;
        word_count_d = word_count_q;
        word_valid_d = word_valid_q;

        idx_acc = idxValid && idxReady;

        lanes_w = asm_q;
        if (idx_acc) begin
            lanes_w[{fill_ptr_q, 4'b0000} +: 16] = indexIn;
        end

        // Indices held after this cycle's write; 4 only on a full event.
        held_cnt = {1'b0, fill_ptr_q} + {2'b00, idx_acc};

        full_ev  = idx_acc && (fill_ptr_q == 2'd3);
        // A flush coinciding with a completing index folds into the full word.
        flush_ev = flush && idxReady && !full_ev && (held_cnt != 3'd0);

        asm_d = lanes_w;
        if (idx_acc) begin
            fill_ptr_d = fill_ptr_q + 2'd1;
        end

        if (full_ev || flush_ev) begin
            // Unwritten lanes already hold PAD, so the padded word is lanes_w.
            indices_d    = lanes_w;
            word_count_d = held_cnt;
            word_valid_d = 1'b1;
            asm_d        = {4{PAD}};
            fill_ptr_d   = 2'd0;
        end else if (word_valid_q && wordReady) begin
            word_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q        <= {4{PAD}};
            fill_ptr_q   <= 2'd0;
            indices_q    <= 64'h0;
            word_count_q <= 3'd0;
            word_valid_q <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            fill_ptr_q   <= fill_ptr_d;
            indices_q    <= indices_d;
            word_count_q <= word_count_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign indices   = indices_q;
    assign wordCount = word_count_q;
    assign wordValid = word_valid_q;

endmodule
